fetch_stage: RTL and testbench

Instruction-fetch front end that drives the instruction memory and loads the IF/ID pipeline register consumed by the decode/execute datapath. It holds the program counter and issues one instruction-memory request at a time over a valid/ready/response handshake. It absorbs decode stalls in a one-entry hold buffer and retargets fetch on branch/jump redirects, discarding any in-flight wrong-path response.

---
 rtl/fetch_stage.sv | 183 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end. Holds the PC, issues one imem
//   request at a time, loads the IF/ID register, absorbs decode stalls in a
//   one-entry hold buffer and retargets on Redirect (wrong-path data dropped).
// Latency: handshake at n, response at n+k, IF/ID valid and next request at n+k+1.
// Backpressure: StallD parks a returned word in the hold buffer (HOLD) and no
//   new request issues until it drains; ImemReqReady low holds ImemAddr steady.
// Ports: clk/rst (sync, active-high); Redirect/PCTarget; StallD/FlushD;
//   ImemReqValid/ImemAddr/ImemReqReady request; ImemRespValid/ImemRespData
//   response; InstrD/PCD/PCPlus4D/ValidD/MisalignD IF/ID outputs.
// Option: define FETCH_MISALIGN_TRAP_EN to trap on misaligned redirect targets
//   (TRAP state, MisalignD marker); otherwise targets are word-aligned on load.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Redirect,
  input  logic [31:0] PCTarget,
  input  logic        StallD,
  input  logic        FlushD,
  output logic        ImemReqValid,
  output logic [31:0] ImemAddr,
  input  logic        ImemReqReady,
  input  logic        ImemRespValid,
  input  logic [31:0] ImemRespData,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        MisalignD
);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {S_REQ, S_WAIT, S_HOLD, S_DROP, S_TRAP} state_t;
`else
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;
`endif

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx, pc_plus4;
  logic [31:0] hold_instr;
  logic [31:0] target;
  logic        hs;
  logic        ld;
  logic [31:0] ld_instr;
  logic        hold_wr, hold_clr;
  logic [31:0] instr_q, pcd_q, pcp4_q;
  logic        vld_q;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        trap_arm, trap_arm_nx;
  logic        ld_mis;
  logic        mis_q;
  assign target    = PCTarget;
  assign MisalignD = mis_q;
`else
  // Low address bits are dropped so a misaligned target fetches its word.
  assign target    = PCTarget & ~32'h3;
  assign MisalignD = 1'b0;
`endif

  assign pc_plus4     = pc + 32'd4;  // wraps modulo 2^32
  assign ImemReqValid = (state == S_REQ) && !rst;
  assign ImemAddr     = pc;
  assign hs           = ImemReqValid && ImemReqReady;

  assign InstrD   = instr_q;
  assign PCD      = pcd_q;
  assign PCPlus4D = pcp4_q;
  assign ValidD   = vld_q;

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    ld       = 1'b0;
    ld_instr = ImemRespData;
    hold_wr  = 1'b0;
    hold_clr = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    trap_arm_nx = trap_arm;
    ld_mis      = 1'b0;
`endif
    if (Redirect) begin
      // Redirect overrides everything; an accepted-but-unanswered request
      // must still be drained in DROP so its response is not taken as ours.
      pc_nx    = target;
      hold_clr = 1'b1;
      case (state)
        S_REQ:   state_nx = hs ? S_DROP : S_REQ;
        S_WAIT:  state_nx = ImemRespValid ? S_REQ : S_DROP;
        S_HOLD:  state_nx = S_REQ;
        S_DROP:  state_nx = S_DROP;
        default: state_nx = S_REQ;
      endcase
`ifdef FETCH_MISALIGN_TRAP_EN
      // Any late response arrives while in TRAP and is ignored there.
      if (PCTarget[1:0] != 2'b00) begin
        state_nx    = S_TRAP;
        trap_arm_nx = 1'b1;
      end
`endif
    end else begin
      case (state)
        S_REQ: if (hs) state_nx = S_WAIT;
        S_WAIT: begin
          if (ImemRespValid) begin
            if (StallD) begin
              hold_wr  = 1'b1;
              state_nx = S_HOLD;
            end else begin
              ld       = 1'b1;
              pc_nx    = pc_plus4;
              state_nx = S_REQ;
            end
          end
        end
        S_HOLD: begin
          if (!StallD) begin
            ld       = 1'b1;
            ld_instr = hold_instr;
            pc_nx    = pc_plus4;
            state_nx = S_REQ;
          end
        end
        S_DROP: if (ImemRespValid) state_nx = S_REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
        S_TRAP: begin
          // One marker per trap entry; then idle until the next Redirect.
          if (trap_arm && !StallD) begin
            ld          = 1'b1;
            ld_instr    = NOP_INSTR;
            ld_mis      = 1'b1;
            trap_arm_nx = 1'b0;
          end
        end
`endif
        default: state_nx = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      hold_instr <= NOP_INSTR;
      instr_q    <= NOP_INSTR;
      pcd_q      <= 32'h0;
      pcp4_q     <= 32'h0;
      vld_q      <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_arm   <= 1'b0;
      mis_q      <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_arm <= trap_arm_nx;
`endif
      if (hold_clr)     hold_instr <= NOP_INSTR;
      else if (hold_wr) hold_instr <= ImemRespData;
      // Flush wins over a same-cycle load; the PC has still advanced.
      if (FlushD) begin
        instr_q <= NOP_INSTR;
        vld_q   <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        mis_q   <= 1'b0;
`endif
      end else if (ld) begin
        instr_q <= ld_instr;
        pcd_q   <= pc;
        pcp4_q  <= pc_plus4;
        vld_q   <= 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
        mis_q   <= ld_mis;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: queued expected requests and IF/ID
// loads are compared by a monitor as the DUT presents them.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Redirect = 1'b0;
  logic [31:0] PCTarget = 32'h0;
  logic        StallD = 1'b0;
  logic        FlushD = 1'b0;
  logic        ImemReqValid;
  logic [31:0] ImemAddr;
  logic        ImemReqReady = 1'b1;
  logic        ImemRespValid = 1'b0;
  logic [31:0] ImemRespData = 32'h0;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD, MisalignD;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pcd;
    logic [31:0] pcp4;
    logic [31:0] instr;
    logic        mis;
  } ifid_t;

  logic [31:0] exp_addr_q[$];
  ifid_t       exp_ifid_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  // memory model state
  int          mem_delay = 1;
  logic        pend = 1'b0;
  logic [31:0] paddr = 32'h0;
  int          cnt = 0;

  // monitor state
  logic        pv = 1'b0, pm = 1'b0;
  logic [31:0] ppc = 32'h0, pin = 32'h0;
  ifid_t       mon_e;

  fetch_stage dut (
    .clk(clk), .rst(rst), .Redirect(Redirect), .PCTarget(PCTarget),
    .StallD(StallD), .FlushD(FlushD),
    .ImemReqValid(ImemReqValid), .ImemAddr(ImemAddr), .ImemReqReady(ImemReqReady),
    .ImemRespValid(ImemRespValid), .ImemRespData(ImemRespData),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD), .MisalignD(MisalignD)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'h1234_5678);
  endfunction

  function automatic ifid_t mk(input logic [31:0] p, input logic [31:0] ins, input logic m);
    ifid_t r;
    r.pcd = p; r.pcp4 = p + 32'd4; r.instr = ins; r.mis = m;
    return r;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_hs(input logic [31:0] a);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(ImemReqValid && ImemReqReady && ImemAddr == a) && k < 60);
    if (!(ImemReqValid && ImemReqReady && ImemAddr == a)) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_hs: no request at %h within 60 cycles", a);
    end
  endtask

  // Memory: answers a handshake mem_delay cycles later, one outstanding.
  initial begin
    forever begin
      @(negedge clk);
      if (ImemReqValid && ImemReqReady) begin
        pend  = 1'b1;
        paddr = ImemAddr;
        cnt   = mem_delay;
      end
      @(posedge clk);
      #1;
      ImemRespValid = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          ImemRespValid = 1'b1;
          ImemRespData  = memf(paddr);
          pend          = 1'b0;
        end
      end
    end
  end

  // Monitor: checks every handshake and every new IF/ID content.
  initial begin
    forever begin
      @(negedge clk);
      if (ImemReqValid && ImemReqReady) begin
        if (exp_addr_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL req_addr: unexpected request at %h", ImemAddr);
        end else begin
          check32("req_addr", ImemAddr, exp_addr_q.pop_front());
        end
      end
      if (ValidD && (!pv || PCD != ppc || InstrD != pin || MisalignD != pm)) begin
        if (exp_ifid_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL ifid: unexpected load pc %h instr %h", PCD, InstrD);
        end else begin
          mon_e = exp_ifid_q.pop_front();
          check32("ifid_pc", PCD, mon_e.pcd);
          check32("ifid_pc4", PCPlus4D, mon_e.pcp4);
          check32("ifid_instr", InstrD, mon_e.instr);
          check32("ifid_mis", {31'b0, MisalignD}, {31'b0, mon_e.mis});
        end
      end
      pv = ValidD; ppc = PCD; pin = InstrD; pm = MisalignD;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Expected request stream, in order.
    exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h100, 32'h104,
                   32'h200, 32'h204, 32'h0, 32'hFFFF_FFFC, 32'h0};
    // Expected IF/ID loads; PC 16, 0x104 and 0x204 never appear.
    exp_ifid_q.push_back(mk(32'h0,   32'h0050_0093, 1'b0));
    exp_ifid_q.push_back(mk(32'h4,   memf(32'h4),   1'b0));
    exp_ifid_q.push_back(mk(32'h8,   memf(32'h8),   1'b0));
    exp_ifid_q.push_back(mk(32'hC,   memf(32'hC),   1'b0));
    exp_ifid_q.push_back(mk(32'h100, memf(32'h100), 1'b0));
    exp_ifid_q.push_back(mk(32'h200, memf(32'h200), 1'b0));
    exp_ifid_q.push_back(mk(32'hFFFF_FFFC, memf(32'hFFFF_FFFC), 1'b0));
`ifdef FETCH_MISALIGN_TRAP_EN
    exp_ifid_q.push_back(mk(32'h102, NOP, 1'b1));
`else
    exp_addr_q.push_back(32'h100);
    exp_ifid_q.push_back(mk(32'h100, memf(32'h100), 1'b0));
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("rst_req_vld", {31'b0, ImemReqValid}, 32'h0);
    check32("rst_addr", ImemAddr, 32'h0);
    check32("rst_instr", InstrD, NOP);
    check32("rst_pcd", PCD, 32'h0);
    check32("rst_pcp4", PCPlus4D, 32'h0);
    check32("rst_valid", {31'b0, ValidD}, 32'h0);
    check32("rst_mis", {31'b0, MisalignD}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // Stall as the response for PC 8 returns, for 3 cycles
    wait_hs(32'h8);
    @(posedge clk); #1 StallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check32("stall_no_req", {31'b0, ImemReqValid}, 32'h0);
      check32("stall_pcd_hold", PCD, 32'h4);
      if (i < 2) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1 StallD = 1'b0;

    // Redirect in WAIT while the response for 16 arrives
    wait_hs(32'h10);
    @(posedge clk); #1 Redirect = 1'b1; PCTarget = 32'h100;
    @(posedge clk); #1 Redirect = 1'b0;

    // Redirect in REQ coinciding with a handshake at 0x104 (drained in DROP)
    wait_hs(32'h100);
    @(posedge clk); #1;
    @(posedge clk); #1 Redirect = 1'b1; PCTarget = 32'h200;
    @(posedge clk); #1 Redirect = 1'b0;

    // Stall and flush together as the 0x200 response arrives
    wait_hs(32'h200);
    @(posedge clk); #1 StallD = 1'b1; FlushD = 1'b1;
    @(posedge clk); #1 StallD = 1'b0; FlushD = 1'b0; mem_delay = 3;
    @(negedge clk);
    check32("flush_valid", {31'b0, ValidD}, 32'h0);
    check32("flush_instr", InstrD, NOP);

    // Reset while waiting; stale response lands the cycle after rst falls
    wait_hs(32'h204);
    @(posedge clk); #1 rst = 1'b1; ImemReqReady = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check32("rst2_valid", {31'b0, ValidD}, 32'h0);
    check32("rst2_addr", ImemAddr, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check32("rst2_valid_after_resp", {31'b0, ValidD}, 32'h0);
    check32("rst2_req_vld", {31'b0, ImemReqValid}, 32'h1);
    check32("rst2_addr_after_resp", ImemAddr, 32'h0);
    @(posedge clk); #1 ImemReqReady = 1'b1; mem_delay = 1;

    // Wrap-around of PC+4 at the top of the address space
    wait_hs(32'h0);
    @(posedge clk); #1 Redirect = 1'b1; PCTarget = 32'hFFFF_FFFC;
    @(posedge clk); #1 Redirect = 1'b0;
    wait_hs(32'hFFFF_FFFC);
    wait_hs(32'h0);

    // Misaligned redirect target
    @(posedge clk); #1 Redirect = 1'b1; PCTarget = 32'h102;
    @(posedge clk); #1 Redirect = 1'b0;
`ifndef FETCH_MISALIGN_TRAP_EN
    wait_hs(32'h100);
    @(posedge clk); #1 ImemReqReady = 1'b0;
`endif

    // Drain and confirm everything expected was seen
    for (int i = 0; i < 30; i++) begin
      if (exp_addr_q.size() == 0 && exp_ifid_q.size() == 0) break;
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    check32("addr_q_empty", exp_addr_q.size(), 32'h0);
    check32("ifid_q_empty", exp_ifid_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
